// File: rtl/spi_bus_monitor.sv
// Passive SPI frame monitor: synchronises SLVSEL/SCLK/MOSI/MISO into PCLK, captures
// MOSI/MISO frames in all four CPOL/CPHA modes, measures SCLK timing and flags protocol errors.
module spi_bus_monitor #(
  parameter int NUM_SS = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1,
  localparam int BC_W  = $clog2(DATA_W) + 1
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic [NUM_SS-1:0] SLVSEL,
  input  logic              SCLK,
  input  logic              MOSI,
  input  logic              MISO,
  output logic              frame_valid,
  output logic [SS_W-1:0]   frame_ss,
  output logic [BC_W-1:0]   frame_bits,
  output logic [DATA_W-1:0] mosi_word,
  output logic [DATA_W-1:0] miso_word,
  output logic [CNT_W-1:0]  sclk_period,
  output logic [CNT_W-1:0]  sclk_high,
  output logic              err_multi_ss,
  output logic              err_overflow,
  output logic              err_mode
);

  localparam logic [BC_W-1:0] BITS_MAX = BC_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state_q, state_d;

  logic [NUM_SS-1:0] ss_p0, ss_p1, ss_p2;
  logic              sclk_p0, sclk_p1, sclk_p2;
  logic              mosi_p0, mosi_p1;
  logic              miso_p0, miso_p1;

  logic              cpol_q, cpha_q;
  logic [SS_W-1:0]   ss_sel_q;
  logic [DATA_W-1:0] mosi_sr, miso_sr;
  logic [BC_W-1:0]   bit_cnt;
  logic              first_seen;
  logic [CNT_W-1:0]  per_cnt, hi_cnt;

  logic              any_low, other_low;
  logic [SS_W-1:0]   low_idx;
  logic              sclk_rise, sclk_fall, samp_edge;
  logic              close, entry, entry_cpol, shift;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [BC_W-1:0] sat_bits(input logic [BC_W-1:0] v);
    return (v == BITS_MAX) ? v : v + 1'b1;
  endfunction

  // Stage p0/p1: two-flop synchronisers; p2: previous value for edge detection
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ss_p0   <= '1;
      ss_p1   <= '1;
      ss_p2   <= '1;
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
      miso_p0 <= 1'b0;
      miso_p1 <= 1'b0;
    end else begin
      ss_p0   <= SLVSEL;
      ss_p1   <= ss_p0;
      ss_p2   <= ss_p1;
      sclk_p0 <= SCLK;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      mosi_p0 <= MOSI;
      mosi_p1 <= mosi_p0;
      miso_p0 <= MISO;
      miso_p1 <= miso_p0;
    end
  end

  always_comb begin
    low_idx = '0;
    any_low = 1'b0;
    for (int i = NUM_SS - 1; i >= 0; i--) begin
      if (!ss_p1[i]) begin
        low_idx = SS_W'(i);
        any_low = 1'b1;
      end
    end
  end

  always_comb begin
    other_low = 1'b0;
    for (int i = 0; i < NUM_SS; i++) begin
      if (!ss_p1[i] && (SS_W'(i) != ss_sel_q)) other_low = 1'b1;
    end
  end

  assign sclk_rise  = sclk_p1 & ~sclk_p2;
  assign sclk_fall  = ~sclk_p1 & sclk_p2;
  assign samp_edge  = (cpol_q ^ cpha_q) ? sclk_fall : sclk_rise;
  assign close      = (ss_p1[ss_sel_q] & ~ss_p2[ss_sel_q]) | (&ss_p1);
  assign entry      = (state_q != ACTIVE) && any_low;
  // Mode registers are still loading on the IDLE->ACTIVE cycle, so use the live config there
  assign entry_cpol = (state_q == IDLE) ? cfg_cpol : cpol_q;
  assign shift      = (state_q == ACTIVE) && !close && samp_edge;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_low) state_d = ACTIVE;
      ACTIVE:  if (close) state_d = DONE;
      DONE:    state_d = any_low ? ACTIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p2 -> outputs: capture, timing measurement and error flags
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      ss_sel_q     <= '0;
      mosi_sr      <= '0;
      miso_sr      <= '0;
      bit_cnt      <= '0;
      first_seen   <= 1'b0;
      per_cnt      <= '0;
      hi_cnt       <= '0;
      frame_valid  <= 1'b0;
      frame_ss     <= '0;
      frame_bits   <= '0;
      mosi_word    <= '0;
      miso_word    <= '0;
      sclk_period  <= '0;
      sclk_high    <= '0;
      err_multi_ss <= 1'b0;
      err_overflow <= 1'b0;
      err_mode     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (state_q == IDLE) begin
        cpol_q <= cfg_cpol;
        cpha_q <= cfg_cpha;
      end
      if (entry) begin
        mosi_sr    <= '0;
        miso_sr    <= '0;
        bit_cnt    <= '0;
        first_seen <= 1'b0;
        per_cnt    <= '0;
        hi_cnt     <= '0;
        ss_sel_q   <= low_idx;
        if (sclk_p1 != entry_cpol) err_mode <= 1'b1;
      end else begin
        if (shift) begin
          mosi_sr    <= {mosi_sr[DATA_W-2:0], mosi_p1};
          miso_sr    <= {miso_sr[DATA_W-2:0], miso_p1};
          bit_cnt    <= sat_bits(bit_cnt);
          first_seen <= 1'b1;
          per_cnt    <= '0;
          if (bit_cnt == BITS_MAX) err_overflow <= 1'b1;
          if (first_seen) sclk_period <= sat_inc(per_cnt);
        end else begin
          per_cnt <= sat_inc(per_cnt);
        end
        if ((state_q == ACTIVE) && sclk_fall) begin
          sclk_high <= hi_cnt;
          hi_cnt    <= '0;
        end else if (sclk_p1) begin
          hi_cnt <= sat_inc(hi_cnt);
        end
        if ((state_q == ACTIVE) && other_low) err_multi_ss <= 1'b1;
        if ((state_q == ACTIVE) && close) begin
          frame_valid <= 1'b1;
          frame_ss    <= ss_sel_q;
          frame_bits  <= bit_cnt;
          mosi_word   <= mosi_sr;
          miso_word   <= miso_sr;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_bus_monitor.sv
// Self-checking bench for spi_bus_monitor: table of SPI frames driven as a master,
// expected frames queued at drive time and compared whenever frame_valid pulses.
module tb_spi_bus_monitor;

  localparam int NUM_SS = 4;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic              cfg_cpol, cfg_cpha;
  logic [NUM_SS-1:0] SLVSEL;
  logic              SCLK, MOSI, MISO;
  logic              frame_valid;
  logic [1:0]        frame_ss;
  logic [5:0]        frame_bits;
  logic [DATA_W-1:0] mosi_word, miso_word;
  logic [CNT_W-1:0]  sclk_period, sclk_high;
  logic              err_multi_ss, err_overflow, err_mode;

  spi_bus_monitor #(.NUM_SS(NUM_SS), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .SLVSEL(SLVSEL), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .frame_valid(frame_valid), .frame_ss(frame_ss), .frame_bits(frame_bits),
    .mosi_word(mosi_word), .miso_word(miso_word),
    .sclk_period(sclk_period), .sclk_high(sclk_high),
    .err_multi_ss(err_multi_ss), .err_overflow(err_overflow), .err_mode(err_mode)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int          ss;
    bit          cpol;
    bit          cpha;
    int          nbits;
    int          half;
    logic [63:0] mosi;
    logic [63:0] miso;
    int          glitch;
    int          abort_at;
    int          exp_bits;
    logic [31:0] exp_mosi;
    logic [31:0] exp_miso;
    int          exp_period;
    int          exp_high;
  } vec_t;

  typedef struct {
    int          ss;
    int          bits;
    logic [31:0] mosi;
    logic [31:0] miso;
    int          period;
    int          high;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   n_pushed = 0;
  int   n_frames = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  always @(posedge PCLK) begin
    #1;
    if (frame_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_frame", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        n_frames++;
        chk("frame_ss",    64'(frame_ss),    64'(mon_e.ss));
        chk("frame_bits",  64'(frame_bits),  64'(mon_e.bits));
        chk("mosi_word",   64'(mosi_word),   64'(mon_e.mosi));
        chk("miso_word",   64'(miso_word),   64'(mon_e.miso));
        chk("sclk_period", 64'(sclk_period), 64'(mon_e.period));
        chk("sclk_high",   64'(sclk_high),   64'(mon_e.high));
      end
    end
  end

  task automatic abort_frame();
    PRESETn = 1'b0;
    wait_cyc(2);
    chk("rst_mid_frame_valid", 64'(frame_valid),  64'd0);
    chk("rst_mid_bits",        64'(frame_bits),   64'd0);
    chk("rst_mid_mosi",        64'(mosi_word),    64'd0);
    chk("rst_mid_period",      64'(sclk_period),  64'd0);
    chk("rst_mid_err_ovf",     64'(err_overflow), 64'd0);
    chk("rst_mid_err_multi",   64'(err_multi_ss), 64'd0);
    SLVSEL = '1;
    SCLK   = cfg_cpol;
    MOSI   = 1'b0;
    MISO   = 1'b0;
    wait_cyc(3);
    PRESETn = 1'b1;
    wait_cyc(8);
  endtask

  task automatic send_frame(input vec_t v);
    if (v.abort_at < 0) begin
      sb.push_back('{v.ss, v.exp_bits, v.exp_mosi, v.exp_miso, v.exp_period, v.exp_high});
      n_pushed++;
    end
    cfg_cpol = v.cpol;
    cfg_cpha = v.cpha;
    SCLK     = v.cpol;
    wait_cyc(6);
    SLVSEL[v.ss] = 1'b0;
    wait_cyc(v.half);
    for (int b = 0; b < v.nbits; b++) begin
      if (b == v.abort_at) begin
        abort_frame();
        return;
      end
      if (b == v.glitch) SLVSEL[v.ss+1] = 1'b0;
      if (!v.cpha) begin
        MOSI = v.mosi[v.nbits-1-b];
        MISO = v.miso[v.nbits-1-b];
        wait_cyc(v.half);
        SCLK = ~SCLK;
        wait_cyc(v.half);
        SCLK = ~SCLK;
      end else begin
        SCLK = ~SCLK;
        MOSI = v.mosi[v.nbits-1-b];
        MISO = v.miso[v.nbits-1-b];
        wait_cyc(v.half);
        SCLK = ~SCLK;
        wait_cyc(v.half);
      end
      if (b == v.glitch) SLVSEL[v.ss+1] = 1'b1;
    end
    wait_cyc(v.half);
    SLVSEL = '1;
    MOSI   = 1'b0;
    MISO   = 1'b0;
    wait_cyc(10);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          ss cpol cpha nbits half mosi                  miso                  glitch abort bits exp_mosi      exp_miso      per high
    vecs[0] = '{0, 1'b0, 1'b0, 8,  5, 64'hA5,              64'h3C,              -1, -1,  8, 32'h000000A5, 32'h0000003C, 10, 5};
    vecs[1] = '{2, 1'b0, 1'b1, 16, 3, 64'hBEEF,            64'h1234,            -1, -1, 16, 32'h0000BEEF, 32'h00001234,  6, 3};
    vecs[2] = '{2, 1'b1, 1'b0, 16, 4, 64'hBEEF,            64'h1234,            -1, -1, 16, 32'h0000BEEF, 32'h00001234,  8, 4};
    vecs[3] = '{2, 1'b1, 1'b1, 16, 6, 64'hBEEF,            64'h1234,            -1, -1, 16, 32'h0000BEEF, 32'h00001234, 12, 6};
    vecs[4] = '{1, 1'b0, 1'b0, 40, 2, 64'hC3_0BADF00D,     64'h5A_CAFEBABE,     -1, -1, 32, 32'h0BADF00D, 32'hCAFEBABE,  4, 2};
    vecs[5] = '{0, 1'b0, 1'b0, 8,  5, 64'h81,              64'h7E,               4, -1,  8, 32'h00000081, 32'h0000007E, 10, 5};
    vecs[6] = '{0, 1'b0, 1'b0, 8,  5, 64'hFF,              64'hFF,              -1,  5,  0, 32'h0,        32'h0,         0, 0};
    vecs[7] = '{3, 1'b1, 1'b1, 8,  5, 64'h96,              64'h69,              -1, -1,  8, 32'h00000096, 32'h00000069, 10, 5};

    PRESETn  = 1'b0;
    cfg_cpol = 1'b0;
    cfg_cpha = 1'b0;
    SLVSEL   = '1;
    SCLK     = 1'b0;
    MOSI     = 1'b0;
    MISO     = 1'b0;
    wait_cyc(3);
    chk("rst_frame_valid", 64'(frame_valid),  64'd0);
    chk("rst_frame_bits",  64'(frame_bits),   64'd0);
    chk("rst_mosi_word",   64'(mosi_word),    64'd0);
    chk("rst_miso_word",   64'(miso_word),    64'd0);
    chk("rst_sclk_period", 64'(sclk_period),  64'd0);
    chk("rst_err_flags",   64'({err_multi_ss, err_overflow, err_mode}), 64'd0);
    PRESETn = 1'b1;
    wait_cyc(5);

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i]);
      case (i)
        3: begin
          chk("modes_err_mode",     64'(err_mode),     64'd0);
          chk("modes_err_overflow", 64'(err_overflow), 64'd0);
          chk("modes_err_multi",    64'(err_multi_ss), 64'd0);
        end
        4: begin
          chk("ovf_err_overflow", 64'(err_overflow), 64'd1);
          chk("ovf_err_mode",     64'(err_mode),     64'd0);
        end
        5: chk("multi_err_multi", 64'(err_multi_ss), 64'd1);
        7: begin
          chk("post_rst_err_flags", 64'({err_multi_ss, err_overflow, err_mode}), 64'd0);
        end
        default: ;
      endcase
    end

    // Zero-bit frame on SS[3] with SCLK at the idle level: timing outputs hold
    sb.push_back('{3, 0, 32'h0, 32'h0, 10, 5});
    n_pushed++;
    cfg_cpol = 1'b0;
    cfg_cpha = 1'b0;
    SCLK     = 1'b0;
    wait_cyc(6);
    SLVSEL[3] = 1'b0;
    wait_cyc(10);
    SLVSEL = '1;
    wait_cyc(10);
    chk("zero_bit_err_mode", 64'(err_mode), 64'd0);

    // Mode 0 with SCLK high when SS falls
    sb.push_back('{0, 0, 32'h0, 32'h0, 10, 5});
    n_pushed++;
    SCLK = 1'b1;
    wait_cyc(6);
    SLVSEL[0] = 1'b0;
    wait_cyc(10);
    SLVSEL = '1;
    wait_cyc(6);
    SCLK = 1'b0;
    wait_cyc(10);
    chk("bad_idle_err_mode", 64'(err_mode), 64'd1);

    chk("frames_seen",   64'(n_frames), 64'(n_pushed));
    chk("sb_left_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
